// File: rtl/recursion_scheduler.sv
// recursion_scheduler
// Time-shares one external complex multiply-add pipeline across N_CH
// first-order complex recursions: state[i] <= state[i] * factor[i] + sample[i].
// When a sample vector is accepted, the block issues one channel per cycle to
// the pipeline. It writes each returning result back into that channel's state
// register, then pulses out_valid once every channel has been updated.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   load                        pulse in IDLE: state[i] <= resetVal[i]
//   resetValR/I                 packed per-channel reload values (N_CH*W)
//   factorR/I                   packed per-channel recursion factors (N_CH*W)
//   in_valid / in_ready         sample vector handshake
//   inR/inI                     packed per-channel sample (N_CH*W)
//   mac_aR/aI, mac_fR/fI        multiplier operands (state, factor)
//   mac_xR/xI                   addend (sample), one cycle after its operands
//   mac_sumR/sumI               pipeline result, two cycles after operand issue
//   outR/outI                   packed channel state registers
//   out_valid                   one-cycle pulse when a sweep completes
//
// state | meaning
// IDLE  | waiting; load or accept a sample vector
// ISSUE | issuing channel idx_q to the pipeline
// DRAIN | all issued, waiting for the last write-back
// DONE  | sweep complete, out_valid high for one cycle
module recursion_scheduler #(
    parameter int N_CH   = 4,
    parameter int n_int  = 8,
    parameter int n_mant = 23,
    localparam int W     = n_int + n_mant + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [N_CH*W-1:0]   resetValR,
    input  logic [N_CH*W-1:0]   resetValI,
    input  logic [N_CH*W-1:0]   factorR,
    input  logic [N_CH*W-1:0]   factorI,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_CH*W-1:0]   inR,
    input  logic [N_CH*W-1:0]   inI,
    output logic [W-1:0]        mac_aR,
    output logic [W-1:0]        mac_aI,
    output logic [W-1:0]        mac_fR,
    output logic [W-1:0]        mac_fI,
    output logic [W-1:0]        mac_xR,
    output logic [W-1:0]        mac_xI,
    input  logic [W-1:0]        mac_sumR,
    input  logic [W-1:0]        mac_sumI,
    output logic [N_CH*W-1:0]   outR,
    output logic [N_CH*W-1:0]   outI,
    output logic                out_valid
);

    localparam int IW = $clog2(N_CH);
    localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t             state_q;
    logic [IW-1:0]      idx_q;
    logic               v1_q, v2_q;
    logic [IW-1:0]      i1_q, i2_q;
    logic [W-1:0]       st_r_q [N_CH];
    logic [W-1:0]       st_i_q [N_CH];
    logic [N_CH*W-1:0]  smp_r_q, smp_i_q;
    logic [W-1:0]       x_r_q, x_i_q;
    logic               out_valid_q;
    logic               issue;

    assign issue     = (state_q == S_ISSUE);
    assign in_ready  = (state_q == S_IDLE) && !load && !rst;
    assign out_valid = out_valid_q;

    assign mac_aR = issue ? st_r_q[idx_q] : '0;
    assign mac_aI = issue ? st_i_q[idx_q] : '0;
    assign mac_fR = issue ? factorR[idx_q*W +: W] : '0;
    assign mac_fI = issue ? factorI[idx_q*W +: W] : '0;
    assign mac_xR = x_r_q;
    assign mac_xI = x_i_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign outR[g*W +: W] = st_r_q[g];
        assign outI[g*W +: W] = st_i_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            i1_q        <= '0;
            i2_q        <= '0;
            smp_r_q     <= '0;
            smp_i_q     <= '0;
            x_r_q       <= '0;
            x_i_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                st_r_q[i] <= '0;
                st_i_q[i] <= '0;
            end
        end else begin
            // two-stage tracker mirrors the pipeline latency so each result
            // lands in the channel that issued it
            v2_q        <= v1_q;
            i2_q        <= i1_q;
            v1_q        <= 1'b0;
            x_r_q       <= '0;
            x_i_q       <= '0;
            out_valid_q <= 1'b0;

            if (v2_q) begin
                st_r_q[i2_q] <= mac_sumR;
                st_i_q[i2_q] <= mac_sumI;
            end

            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        for (int i = 0; i < N_CH; i++) begin
                            st_r_q[i] <= resetValR[i*W +: W];
                            st_i_q[i] <= resetValI[i*W +: W];
                        end
                    end else if (in_valid) begin
                        smp_r_q <= inR;
                        smp_i_q <= inI;
                        idx_q   <= '0;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    v1_q  <= 1'b1;
                    i1_q  <= idx_q;
                    // addend trails the multiplier operands by one cycle
                    x_r_q <= smp_r_q[idx_q*W +: W];
                    x_i_q <= smp_i_q[idx_q*W +: W];
                    if (idx_q == LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_DRAIN: begin
                    if (v2_q && (i2_q == LAST)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recursion_scheduler.sv
module tb_recursion_scheduler;
    localparam int N_CH = 4;
    localparam int NI   = 8;
    localparam int NM   = 23;
    localparam int W    = NI + NM + 1;
    localparam int VW   = N_CH * W;
    localparam logic [W-1:0] ONE  = 32'h0080_0000;
    localparam logic [W-1:0] HALF = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst, load, in_valid, in_ready, out_valid;
    logic [VW-1:0] resetValR, resetValI, factorR, factorI, inR, inI, outR, outI;
    logic [W-1:0] mac_aR, mac_aI, mac_fR, mac_fI, mac_xR, mac_xI, mac_sumR, mac_sumI;

    always #5 clk = ~clk;

    recursion_scheduler #(.N_CH(N_CH), .n_int(NI), .n_mant(NM)) dut (
        .clk(clk), .rst(rst), .load(load),
        .resetValR(resetValR), .resetValI(resetValI),
        .factorR(factorR), .factorI(factorI),
        .in_valid(in_valid), .in_ready(in_ready),
        .inR(inR), .inI(inI),
        .mac_aR(mac_aR), .mac_aI(mac_aI), .mac_fR(mac_fR), .mac_fI(mac_fI),
        .mac_xR(mac_xR), .mac_xI(mac_xI),
        .mac_sumR(mac_sumR), .mac_sumI(mac_sumI),
        .outR(outR), .outI(outI), .out_valid(out_valid)
    );

    // fixed-point complex multiply, result truncated to W bits
    function automatic logic [2*W-1:0] cmul(input logic [W-1:0] aR, aI, fR, fI);
        longint ar, ai, fr, fi, re, im;
        ar = $signed(aR); ai = $signed(aI); fr = $signed(fR); fi = $signed(fI);
        re = (ar * fr - ai * fi) >>> NM;
        im = (ar * fi + ai * fr) >>> NM;
        return {re[W-1:0], im[W-1:0]};
    endfunction

    // external pipeline: product registered, then sum with the late addend
    logic [W-1:0] p1r = '0, p1i = '0, sr = '0, si = '0;
    always @(posedge clk) begin
        {p1r, p1i} <= cmul(mac_aR, mac_aI, mac_fR, mac_fI);
        sr <= p1r + mac_xR;
        si <= p1i + mac_xI;
    end
    assign mac_sumR = sr;
    assign mac_sumI = si;

    int total = 0, bad = 0, cyc = 0, busy_end = 0, acc_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s @cyc %0d: got timeout want completion", nm, cyc);
    endtask

    // golden channel states and scoreboard
    logic [W-1:0] gR [N_CH];
    logic [W-1:0] gI [N_CH];
    typedef struct { int c; logic [VW-1:0] r; logic [VW-1:0] i; } exp_t;
    exp_t sbq[$];

    function automatic logic [VW-1:0] pack(input logic [W-1:0] a [N_CH]);
        logic [VW-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i*W +: W] = a[i];
        return v;
    endfunction

    initial for (int i = 0; i < N_CH; i++) begin gR[i] = '0; gI[i] = '0; end

    // reference model: tracks busy/idle itself, predicts handshake and results
    always @(negedge clk) begin
        bit idle, exp_rdy;
        idle    = (cyc >= busy_end);
        exp_rdy = idle && !load && !rst;
        chk("in_ready", VW'(in_ready), VW'(exp_rdy));
        if (idle && !rst) begin
            chk("idle_outR", outR, pack(gR));
            chk("idle_outI", outI, pack(gI));
            chk("idle_mac_zero", {mac_aR, mac_aI, mac_fR, mac_xR}, '0);
        end
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin gR[i] = '0; gI[i] = '0; end
            sbq.delete();
            busy_end = 0;
        end else if (idle && load) begin
            for (int i = 0; i < N_CH; i++) begin
                gR[i] = resetValR[i*W +: W];
                gI[i] = resetValI[i*W +: W];
            end
        end else if (exp_rdy && in_valid) begin
            exp_t e;
            for (int i = 0; i < N_CH; i++) begin
                logic [W-1:0] pr, pi;
                {pr, pi} = cmul(gR[i], gI[i], factorR[i*W +: W], factorI[i*W +: W]);
                gR[i] = pr + inR[i*W +: W];
                gI[i] = pi + inI[i*W +: W];
            end
            e.c = cyc + N_CH + 3;
            e.r = pack(gR);
            e.i = pack(gI);
            sbq.push_back(e);
            busy_end = cyc + N_CH + 4;
            acc_cnt++;
        end
    end

    // monitor: compares each completion against the scoreboard
    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", VW'(1), VW'(0));
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("done_cycle", VW'(cyc), VW'(e.c));
                chk("done_outR", outR, e.r);
                chk("done_outI", outI, e.i);
            end
        end else if (sbq.size() > 0 && sbq[0].c <= cyc) begin
            chk("missing_out_valid", VW'(0), VW'(1));
            void'(sbq.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (cyc < busy_end && n < 100) begin step(); n++; end
        if (cyc < busy_end) fail_now("wait_idle");
    endtask

    task automatic pulse_load();
        load = 1'b1; step(); load = 1'b0;
    endtask

    task automatic send(input int n, input bit zero);
        int target = acc_cnt + n;
        int budget = n * (N_CH + 4) + 20;
        in_valid = 1'b1;
        while (acc_cnt < target && budget > 0) begin
            if (!zero) begin inR = rnd_vec(); inI = rnd_vec(); end
            step();
            budget--;
        end
        in_valid = 1'b0;
        if (acc_cnt < target) fail_now("send");
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; in_valid = 1'b0;
        resetValR = '0; resetValI = '0; factorR = '0; factorI = '0; inR = '0; inI = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // 1.0 * 0.5 + 0 on channel 0
        resetValR = rnd_vec(); resetValI = rnd_vec();
        factorR = rnd_vec(); factorI = rnd_vec();
        resetValR[W-1:0] = ONE; resetValI[W-1:0] = '0;
        factorR[W-1:0] = HALF; factorI[W-1:0] = '0;
        pulse_load();
        inR = '0; inI = '0;
        send(1, 1'b1);
        wait_idle();
        chk("half_outR0", VW'(outR[W-1:0]), VW'(HALF));
        chk("half_outI0", VW'(outI[W-1:0]), VW'(0));

        // rotation by j: 1 -> j -> -1 -> -j -> 1
        for (int i = 0; i < N_CH; i++) begin
            resetValR[i*W +: W] = ONE; resetValI[i*W +: W] = '0;
            factorR[i*W +: W] = '0; factorI[i*W +: W] = ONE;
        end
        pulse_load();
        inR = '0; inI = '0;
        send(4, 1'b1);
        wait_idle();
        chk("rot_outR", outR, {N_CH{ONE}});
        chk("rot_outI", outI, '0);

        // load and in_valid together: load wins, sample accepted next cycle
        resetValR = rnd_vec(); resetValI = rnd_vec();
        factorR = rnd_vec(); factorI = rnd_vec();
        load = 1'b1; in_valid = 1'b1;
        step();
        load = 1'b0;
        send(1, 1'b0);
        wait_idle();

        // reset three cycles into a sweep
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("rst_abort_outR", outR, '0);

        // back-to-back stream of ten samples
        resetValR = rnd_vec(); resetValI = rnd_vec();
        pulse_load();
        send(10, 1'b0);
        wait_idle();

        // random mix of loads, samples and ignored requests while busy
        for (int n = 0; n < 300; n++) begin
            load      = ($urandom_range(0, 7) == 0);
            in_valid  = $urandom_range(0, 1);
            resetValR = rnd_vec(); resetValI = rnd_vec();
            inR       = rnd_vec(); inI = rnd_vec();
            step();
        end
        load = 1'b0; in_valid = 1'b0;
        wait_idle();
        repeat (3) step();
        chk("scoreboard_empty", VW'(sbq.size()), VW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
